// File: rtl/delay_sum_beamformer.sv
// N-channel receive delay-and-sum beamformer: per-channel circular history, a one-channel-per-cycle
// steering-delay engine with clamping, and a registered mean of the aligned samples.
module delay_sum_beamformer #(
  parameter int NUM_CH          = 4,
  parameter int SAMPLE_W        = 16,
  parameter int DEPTH           = 128,
  parameter int SIN_WIDTH       = 17,
  parameter int ELEMENT_SPACING = 9,
  parameter int SPEED_OF_SOUND  = 343000,
  parameter int SAMPLING_RATE   = 1000000,
  parameter int FRAC            = 8
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  adc_in,
  input  logic                             data_valid_in,
  input  logic [SIN_WIDTH-1:0]             sin_theta,
  input  logic                             sign_bit,
  input  logic                             angle_valid_in,
  output logic                             angle_ready_out,
  output logic                             busy_out,
  output logic                             delay_sat_out,
  output logic                             data_valid_out,
  output logic [SAMPLE_W-1:0]              aggregated_waveform
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int AW    = $clog2(DEPTH);
  localparam int SUM_W = SAMPLE_W + CH_W;
  localparam int SHIFT = SIN_WIDTH - 1 + FRAC;
  localparam logic [63:0] STEP_Q = (64'(ELEMENT_SPACING) * 64'(SAMPLING_RATE) * (64'd1 << FRAC))
                                   / 64'(SPEED_OF_SOUND);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [AW-1:0]   MAX_DLY  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nxt;

  // Angle handshake: a request is taken on any edge where angle_valid_in && angle_ready_out;
  // ready is high only in IDLE, so requests presented during CALC are simply not taken.
  logic accept;
  assign accept = angle_valid_in && angle_ready_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  logic [CH_W-1:0] ch;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (angle_valid_in) state_nxt = CALC;
      CALC:    if (ch == LAST_CH)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    angle_ready_out = (state == IDLE);
    busy_out        = (state == CALC);
  end

  logic [SIN_WIDTH-1:0] sin_q;
  logic                 sign_q;
  logic                 clamp_acc;
  logic [AW-1:0]        shadow [NUM_CH];
  logic [AW-1:0]        delay  [NUM_CH];
  logic [CH_W-1:0]      k;
  logic [63:0]          d_raw;
  logic                 clamp_now;
  logic [AW-1:0]        d_new;

  // Negative angles mirror the array, so the last channel becomes the zero-delay reference.
  assign k         = sign_q ? (LAST_CH - ch) : ch;
  assign d_raw     = (STEP_Q * 64'(k) * 64'(sin_q)) >> SHIFT;
  assign clamp_now = (d_raw > 64'(DEPTH - 1));
  assign d_new     = clamp_now ? MAX_DLY : d_raw[AW-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sin_q         <= '0;
      sign_q        <= 1'b0;
      ch            <= '0;
      clamp_acc     <= 1'b0;
      delay_sat_out <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        delay[i]  <= '0;
      end
    end else if (accept) begin
      sin_q     <= sin_theta;
      sign_q    <= sign_bit;
      ch        <= '0;
      clamp_acc <= 1'b0;
    end else if (state == CALC) begin
      shadow[ch] <= d_new;
      clamp_acc  <= clamp_acc | clamp_now;
      ch         <= ch + 1'b1;
      // Commit every channel on the same edge so the data path never sees a mixed set.
      if (ch == LAST_CH) begin
        for (int i = 0; i < NUM_CH; i++)
          delay[i] <= (CH_W'(i) == ch) ? d_new : shadow[i];
        delay_sat_out <= clamp_acc | clamp_now;
      end
    end
  end

  logic [SAMPLE_W-1:0] hist [NUM_CH][DEPTH];
  logic [AW-1:0]       wr;
  logic [AW-1:0]       fill;

  always_ff @(posedge clk_in) begin
    if (data_valid_in)
      for (int i = 0; i < NUM_CH; i++) hist[i][wr] <= adc_in[i];
  end

  logic [SAMPLE_W-1:0] term [NUM_CH];
  logic [SUM_W-1:0]    sum;
  logic [AW-1:0]       max_d;
  logic                out_ok;

  always_comb begin
    sum   = '0;
    max_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      term[i] = (delay[i] == '0) ? adc_in[i] : hist[i][AW'(wr - delay[i])];
      sum     = sum + {{CH_W{term[i][SAMPLE_W-1]}}, term[i]};
      if (delay[i] > max_d) max_d = delay[i];
    end
  end

  assign out_ok = data_valid_in && (fill >= max_d);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr                  <= '0;
      fill                <= '0;
      data_valid_out      <= 1'b0;
      aggregated_waveform <= '0;
    end else begin
      data_valid_out <= out_ok;
      // Dropping the low bits of a two's-complement sum is an arithmetic floor division.
      if (out_ok) aggregated_waveform <= sum[SUM_W-1:CH_W];
      if (data_valid_in) begin
        wr <= wr + 1'b1;
        if (fill != MAX_DLY) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer: expected outputs queued at issue time, checked by a
// negedge monitor; a DEPTH=32 instance shares the stimulus to exercise delay clamping.
module tb_delay_sum_beamformer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0][W-1:0] adc    = '0;
  logic              dv_in  = 1'b0;
  logic [16:0]       sin_t  = '0;
  logic              sgn    = 1'b0;
  logic              ang_v  = 1'b0;

  logic          ready, busy, sat, dvo;
  logic [W-1:0]  agg;
  logic          ready32, busy32, sat32, dvo32;
  logic [W-1:0]  agg32;

  delay_sum_beamformer u_dut (
    .clk_in(clk), .rst_in(rst), .adc_in(adc), .data_valid_in(dv_in),
    .sin_theta(sin_t), .sign_bit(sgn), .angle_valid_in(ang_v),
    .angle_ready_out(ready), .busy_out(busy), .delay_sat_out(sat),
    .data_valid_out(dvo), .aggregated_waveform(agg)
  );

  delay_sum_beamformer #(.DEPTH(32)) u_dut32 (
    .clk_in(clk), .rst_in(rst), .adc_in(adc), .data_valid_in(dv_in),
    .sin_theta(sin_t), .sign_bit(sgn), .angle_valid_in(ang_v),
    .angle_ready_out(ready32), .busy_out(busy32), .delay_sat_out(sat32),
    .data_valid_out(dvo32), .aggregated_waveform(agg32)
  );

  int vectors    = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dvo) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got 0x%0h expected no output", agg);
      end else begin
        exp_v = exp_q.pop_front();
        if (agg !== exp_v) begin
          miscompares++;
          $display("FAIL sample_out: got 0x%0h expected 0x%0h", agg, exp_v);
        end
      end
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    dv_in = 1'b0;
    ang_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                      input logic [W-1:0] a3, input bit ev, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    adc[0] = a0; adc[1] = a1; adc[2] = a2; adc[3] = a3;
    dv_in  = 1'b1;
    if (ev) exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    @(posedge clk);
    #1 dv_in = 1'b0;
    adc = '0;
    repeat (2) @(posedge clk);
    #1 check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Issues one angle and follows the engine through its NUM_CH busy cycles; with poke set a
  // second request is presented while busy and must not be taken.
  task automatic request(input logic [16:0] s, input logic sg, input bit poke);
    @(posedge clk);
    #1;
    dv_in = 1'b0;
    sin_t = s;
    sgn   = sg;
    ang_v = 1'b1;
    @(posedge clk);
    #1 ang_v = 1'b0;
    check("busy_c0", 32'(busy), 32'd1);
    check("ready_c0", 32'(ready), 32'd0);
    for (int c = 1; c < 4; c++) begin
      if (poke && c == 1) begin
        ang_v = 1'b1;
        sin_t = 17'h0;
        sgn   = ~sg;
      end
      @(posedge clk);
      #1 ang_v = 1'b0;
      check("busy_calc", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    check("busy_done", 32'(busy), 32'd0);
    check("ready_done", 32'(ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(dvo), 32'd0);
    check("rst_agg", 32'(agg), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    do_reset();

    // Ramp, zero delays: output equals input from the first sample
    for (int n = 0; n < 10; n++)
      send(16'(n), 16'(n), 16'(n), 16'(n), 1'b1, 16'(n));
    drain("drain_ramp");

    // Positive angle 1.0: delays {0,26,52,78}; a stray request during CALC is ignored
    do_reset();
    request(17'h10000, 1'b0, 1'b1);
    check("sat_pos", 32'(sat), 32'd0);
    check("sat32_pos", 32'(sat32), 32'd1);
    check("ready32", 32'(ready32), 32'd1);
    for (int n = 0; n < 86; n++)
      send((n == 78) ? 16'd1000 : 16'd0, (n == 52) ? 16'd1000 : 16'd0,
           (n == 26) ? 16'd1000 : 16'd0, (n == 0)  ? 16'd1000 : 16'd0,
           (n >= 78), (n == 78) ? 16'd1000 : 16'd0);
    drain("drain_pos");

    // Negative angle 1.0: delays {78,52,26,0}
    do_reset();
    request(17'h10000, 1'b1, 1'b0);
    check("sat_neg", 32'(sat), 32'd0);
    check("sat32_neg", 32'(sat32), 32'd1);
    for (int n = 0; n < 86; n++)
      send((n == 0)  ? 16'd1000 : 16'd0, (n == 26) ? 16'd1000 : 16'd0,
           (n == 52) ? 16'd1000 : 16'd0, (n == 78) ? 16'd1000 : 16'd0,
           (n >= 78), (n == 78) ? 16'd1000 : 16'd0);
    drain("drain_neg");

    // Broadside again: delays back to 0, clamp flag clears; signed mean corners
    request(17'h00000, 1'b0, 1'b0);
    check("sat_clear", 32'(sat), 32'd0);
    check("sat32_clear", 32'(sat32), 32'd0);
    send(16'd10,    16'd20,    16'd30,    16'd40,    1'b1, 16'd25);
    send(16'hFFFC,  16'hFFFD,  16'hFFFE,  16'hFFFE,  1'b1, 16'hFFFD);
    send(16'd1,     16'd0,     16'd0,     16'd0,     1'b1, 16'd0);
    send(16'hFFFF,  16'd0,     16'd0,     16'd0,     1'b1, 16'hFFFF);
    send(16'h7FFF,  16'h7FFF,  16'h7FFF,  16'h7FFF,  1'b1, 16'h7FFF);
    send(16'h8000,  16'h8000,  16'h8000,  16'h8000,  1'b1, 16'h8000);
    send(16'h7FFF,  16'h8000,  16'h7FFF,  16'h8000,  1'b1, 16'hFFFF);
    drain("drain_mix");

    // Full-scale sin clamps channel 3 at DEPTH=128 too
    request(17'h1FFFF, 1'b0, 1'b0);
    check("sat_full", 32'(sat), 32'd1);

    // Async reset in the middle of CALC
    @(posedge clk);
    #1;
    sin_t = 17'h10000;
    sgn   = 1'b0;
    ang_v = 1'b1;
    @(posedge clk);
    #1 ang_v = 1'b0;
    check("busy_pre_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(dvo), 32'd0);
    check("mid_rst_agg", 32'(agg), 32'd0);
    check("mid_rst_sat", 32'(sat), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Delays must be zero after the interrupted request
    send(16'd1, 16'd2, 16'd3,  16'd4,  1'b1, 16'd2);
    send(16'd2, 16'd4, 16'd6,  16'd8,  1'b1, 16'd5);
    send(16'd3, 16'd6, 16'd9,  16'd12, 1'b1, 16'd7);
    send(16'd4, 16'd8, 16'd12, 16'd16, 1'b1, 16'd10);
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
